// File: rtl/key_digit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_digit_ctrl_pkg
// Description : Shared key-FSM state encoding and display constants.
// Revision    : 1.0 - initial release
// ============================================================================
package key_digit_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        DEBOUNCE = ST_DEBOUNCE,
        HELD     = ST_HELD
    } key_state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Keypad debounce FSM; emits committed code and accept pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_digit_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_accept,
    output logic [3:0] key_last
);

    localparam int              c_CW   = cnt_width(DEB_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEB_CYCLES - 1);
    // The IDLE->DEBOUNCE sample is the first stable one, so the count
    // reaches DEB_CYCLES-1 on the edge that sees it at DEB_CYCLES-2.
    localparam logic [c_CW-1:0] c_PRE  = c_CW'(DEB_CYCLES - 2);

    key_state_t      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_cand;
    logic            r_accept;
    logic [3:0]      r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cand   <= '0;
            r_accept <= 1'b0;
            r_last   <= '0;
        end else begin
            r_accept <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (key_valid) begin
                        r_state <= DEBOUNCE;
                        r_cnt   <= '0;
                        r_cand  <= key_code;
                    end
                end
                DEBOUNCE: begin
                    if (!key_valid) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (key_code != r_cand) begin
                        r_cnt  <= '0;
                        r_cand <= key_code;
                    end else if (r_cnt == c_PRE) begin
                        r_state  <= HELD;
                        r_cnt    <= '0;
                        r_accept <= 1'b1;
                        r_last   <= r_cand;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                HELD: begin
                    // Release must be continuous; any bounce back restarts it.
                    if (key_valid) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_accept = r_accept;
    assign key_last   = r_last;

endmodule
`default_nettype wire

// File: rtl/key_digit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_digit_ctrl
// Description : Debounced keypad entry into a 4-digit buffer with mux refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module key_digit_ctrl
    import key_digit_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES     = 1000000,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] digit_sel,
    output logic [3:0] digit_val,
    output logic       digit_blank,
    output logic       key_accept,
    output logic [3:0] key_last
);

    localparam int              c_RW       = cnt_width(REFRESH_CYCLES);
    localparam logic [c_RW-1:0] c_REF_LAST = c_RW'(REFRESH_CYCLES - 1);
    localparam logic [2:0]      c_FULL     = 3'(NUM_DIGITS);

    logic            w_accept;
    logic [3:0]      w_code;
    logic [3:0]      r_buf [NUM_DIGITS];
    logic [2:0]      r_count;
    logic [c_RW-1:0] r_ref_cnt;
    logic [1:0]      r_idx;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_accept (w_accept),
        .key_last   (w_code)
    );

    // Newest entry lives in digit 0; a full buffer drops digit 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            if (w_code == KEY_CLEAR) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= '0;
                r_count <= '0;
            end else begin
                for (int i = NUM_DIGITS - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
                r_buf[0] <= w_code;
                if (r_count != c_FULL) r_count <= r_count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (r_ref_cnt == c_REF_LAST) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + c_RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel   <= 4'b1110;
            digit_val   <= '0;
            digit_blank <= 1'b1;
        end else begin
            digit_sel   <= ~(4'b0001 << r_idx);
            digit_val   <= r_buf[r_idx];
            digit_blank <= ({1'b0, r_idx} >= r_count);
        end
    end

    assign key_accept = w_accept;
    assign key_last   = w_code;

endmodule
`default_nettype wire
